// File: rtl/eds_pkg.sv
// Shared types and helpers for the delayed-event scheduler: the mode encoding,
// the default deadline type and a comparison for deadlines that wrap.
package eds_pkg;

    typedef enum logic {
        EDS_BLOCKING = 1'b0,
        EDS_QUEUED   = 1'b1
    } eds_mode_e;

    localparam int unsigned EDS_DLY_W = 8;

    typedef logic [EDS_DLY_W:0] deadline_t;

    // Compares a and b by their distance ahead of now, modulo 2^w. This is
    // valid while every live deadline is less than half the wrap period ahead.
    function automatic logic deadline_ge(
        input logic [31:0]  a,
        input logic [31:0]  b,
        input logic [31:0]  now,
        input int unsigned  w
    );
        logic [31:0] mask;
        logic [31:0] da;
        logic [31:0] db;
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        da   = (a - now) & mask;
        db   = (b - now) & mask;
        return da >= db;
    endfunction

endpackage

// File: rtl/eds_channel.sv
// One scheduler channel: mode latch, deadline FIFO in expiry order, expiry
// compare against the shared timestamp, and a saturating drop counter.
module eds_channel
    import eds_pkg::*;
#(
    parameter int unsigned DLY_W    = 8,
    parameter int unsigned MAX_PEND = 4,
    parameter int unsigned DROP_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig,
    input  logic [DLY_W-1:0]  dly,
    input  logic              mode,
    input  logic [DLY_W:0]    tstamp,
    output logic              fire,
    output logic              busy,
    output logic              drop,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int unsigned PTR_W = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    if ((MAX_PEND < 2) || ((MAX_PEND & (MAX_PEND - 1)) != 0)) begin : g_bad_depth
        $error("eds_channel: MAX_PEND must be a power of two and at least 2");
    end

    logic [DLY_W:0]   fifo [MAX_PEND];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    eds_mode_e        mode_q;
    eds_mode_e        mode_eff;
    logic [DLY_W-1:0] dly_eff;
    logic [DLY_W:0]   deadline;
    logic [DLY_W:0]   head;
    logic [DLY_W:0]   tail;
    logic             pending;
    logic             full;
    logic             pop;
    logic             push;
    logic             order_ok;

    assign pending  = (count != '0);
    assign full     = (count == CNT_W'(MAX_PEND));
    assign head     = fifo[rd_ptr];
    assign tail     = fifo[wr_ptr - PTR_W'(1)];
    assign pop      = pending && (head == tstamp) && !rst;
    assign dly_eff  = (dly == '0) ? DLY_W'(1) : dly;
    assign deadline = tstamp + {1'b0, dly_eff};

    // An idle channel follows the mode input directly so a same-cycle trig
    // is handled under the freshly latched mode.
    assign mode_eff = pending ? mode_q : eds_mode_e'(mode);

    // Strictly later than the tail keeps FIFO order equal to expiry order and
    // rules out two fires from one channel in a single cycle.
    assign order_ok = !pending ||
                      ((deadline != tail) &&
                       deadline_ge(32'(deadline), 32'(tail), 32'(tstamp), DLY_W + 1));

    always_comb begin
        push = 1'b0;
        if (trig && !rst) begin
            unique case (mode_eff)
                EDS_BLOCKING: push = !pending;
                EDS_QUEUED:   push = (!full || pop) && order_ok;
                default:      push = 1'b0;
            endcase
        end
    end

    assign fire = pop;
    assign busy = pending;
    assign drop = trig && !rst && !push;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= deadline;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            mode_q   <= EDS_BLOCKING;
            drop_cnt <= '0;
        end else begin
            if (!pending) begin
                mode_q <= eds_mode_e'(mode);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end
    end

endmodule

// File: rtl/event_delay_sched.sv
// Multi-channel delayed-event scheduler: owns the shared free-running timestamp
// and slices the flat ports across independent eds_channel instances.
module event_delay_sched
    import eds_pkg::*;
#(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned DLY_W    = 8,
    parameter int unsigned MAX_PEND = 4,
    parameter int unsigned DROP_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        trig,
    input  logic [NUM_CH*DLY_W-1:0]  dly,
    input  logic [NUM_CH-1:0]        mode,
    output logic [NUM_CH-1:0]        fire,
    output logic [NUM_CH-1:0]        busy,
    output logic [NUM_CH-1:0]        drop,
    output logic [NUM_CH*DROP_W-1:0] drop_cnt,
    output logic [DLY_W:0]           tstamp
);

    always_ff @(posedge clk) begin
        if (rst) begin
            tstamp <= '0;
        end else begin
            tstamp <= tstamp + {{DLY_W{1'b0}}, 1'b1};
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        eds_channel #(
            .DLY_W    (DLY_W),
            .MAX_PEND (MAX_PEND),
            .DROP_W   (DROP_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .trig     (trig[i]),
            .dly      (dly[i*DLY_W +: DLY_W]),
            .mode     (mode[i]),
            .tstamp   (tstamp),
            .fire     (fire[i]),
            .busy     (busy[i]),
            .drop     (drop[i]),
            .drop_cnt (drop_cnt[i*DROP_W +: DROP_W])
        );
    end

endmodule

// File: tb/tb_event_delay_sched.sv
// Randomised and directed bench for event_delay_sched against an absolute-time
// model: deadlines are plain cycle numbers, ordering is ordinary integer compare.
module tb_event_delay_sched;

    localparam int NCH = 2;
    localparam int DW  = 4;
    localparam int MP  = 4;
    localparam int CW  = 4;
    localparam int TS_MOD = 1 << (DW + 1);
    localparam int CNT_MAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    trig;
    logic [NCH*DW-1:0] dly;
    logic [NCH-1:0]    mode;
    logic [NCH-1:0]    fire;
    logic [NCH-1:0]    busy;
    logic [NCH-1:0]    drop;
    logic [NCH*CW-1:0] drop_cnt;
    logic [DW:0]       tstamp;

    event_delay_sched #(
        .NUM_CH   (NCH),
        .DLY_W    (DW),
        .MAX_PEND (MP),
        .DROP_W   (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .trig     (trig),
        .dly      (dly),
        .mode     (mode),
        .fire     (fire),
        .busy     (busy),
        .drop     (drop),
        .drop_cnt (drop_cnt),
        .tstamp   (tstamp)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model state: absolute cycle number since reset release and, per channel,
    // the accepted deadlines (absolute cycles) in acceptance order.
    int cyc;
    int pend [NCH][MP+1];
    int npend [NCH];
    bit mreg [NCH];
    int dcnt [NCH];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        cyc = 0;
        for (int c = 0; c < NCH; c++) begin
            npend[c] = 0;
            mreg[c]  = 1'b0;
            dcnt[c]  = 0;
        end
    endtask

    task automatic step_and_check();
        bit e_fire, e_busy, e_drop, acc, m;
        int d, dl;
        #1;
        if (rst) begin
            check_eq("fire_in_rst", 32'(fire), 0);
            check_eq("drop_in_rst", 32'(drop), 0);
            model_reset();
        end else begin
            check_eq("tstamp", 32'(tstamp), cyc % TS_MOD);
            for (int c = 0; c < NCH; c++) begin
                e_fire = (npend[c] > 0) && (pend[c][0] == cyc);
                e_busy = (npend[c] > 0);
                m      = e_busy ? mreg[c] : mode[c];
                d      = int'(dly[c*DW +: DW]);
                if (d == 0) d = 1;
                dl     = cyc + d;
                if (!m) acc = (npend[c] == 0);
                else    acc = (npend[c] < MP || e_fire) &&
                              (npend[c] == 0 || dl > pend[c][npend[c]-1]);
                acc    = acc && trig[c];
                e_drop = trig[c] && !acc;

                check_eq($sformatf("fire%0d", c), 32'(fire[c]), 32'(e_fire));
                check_eq($sformatf("busy%0d", c), 32'(busy[c]), 32'(e_busy));
                check_eq($sformatf("drop%0d", c), 32'(drop[c]), 32'(e_drop));
                check_eq($sformatf("drop_cnt%0d", c), 32'(drop_cnt[c*CW +: CW]), dcnt[c]);

                if (!e_busy) mreg[c] = mode[c];
                if (e_fire) begin
                    for (int k = 0; k < MP; k++) pend[c][k] = pend[c][k+1];
                    npend[c]--;
                end
                if (acc) begin
                    pend[c][npend[c]] = dl;
                    npend[c]++;
                end
                if (e_drop && dcnt[c] < CNT_MAX) dcnt[c]++;
            end
            cyc++;
        end
    endtask

    task automatic drive(input logic r, input logic [NCH-1:0] t, input logic [NCH-1:0] md,
                         input logic [NCH*DW-1:0] dv);
        @(negedge clk);
        rst  = r;
        trig = t;
        mode = md;
        dly  = dv;
        step_and_check();
    endtask

    task automatic idle(input int n, input logic [NCH-1:0] md);
        for (int i = 0; i < n; i++) drive(1'b0, '0, md, '0);
    endtask

    initial begin
        logic [NCH-1:0]    rt, rm;
        logic [NCH*DW-1:0] rd;
        int density;

        rst = 1'b1; trig = '0; mode = '0; dly = '0;
        model_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, '0, '0, '0);

        // Reset state and counting timestamp.
        idle(10, 2'b00);

        // Blocking ch0, dly=3, trig every cycle: accept, drop x3, repeat.
        for (int i = 0; i < 14; i++) drive(1'b0, 2'b01, 2'b00, {4'd0, 4'd3});
        idle(6, 2'b00);

        // Queued ch1, dly=5, six back-to-back trigs: full drop then same-cycle pop.
        for (int i = 0; i < 6; i++) drive(1'b0, 2'b10, 2'b10, {4'd5, 4'd0});
        idle(8, 2'b10);

        // Queued ch0: later-deadline first, then an earlier one that must drop.
        drive(1'b0, 2'b01, 2'b01, {4'd0, 4'd10});
        drive(1'b0, 2'b01, 2'b01, {4'd0, 4'd2});
        idle(12, 2'b01);

        // Equal deadlines: dly=4 then dly=3 one cycle later collide.
        drive(1'b0, 2'b01, 2'b01, {4'd0, 4'd4});
        drive(1'b0, 2'b01, 2'b01, {4'd0, 4'd3});
        idle(6, 2'b01);

        // Timestamp wrap: trig at tstamp 30 with dly=5 expires at tstamp 3.
        for (int i = 0; i < TS_MOD && (cyc % TS_MOD) != 30; i++) idle(1, 2'b00);
        drive(1'b0, 2'b11, 2'b10, {4'd5, 4'd5});
        idle(8, 2'b00);

        // Reset mid-delay: pending fire must never occur.
        drive(1'b0, 2'b01, 2'b00, {4'd0, 4'd8});
        idle(1, 2'b00);
        drive(1'b1, 2'b01, 2'b00, {4'd0, 4'd1});
        idle(10, 2'b00);

        // Mode change while busy: ch1 stays queued until it drains.
        drive(1'b0, 2'b10, 2'b10, {4'd12, 4'd0});
        drive(1'b0, 2'b10, 2'b00, {4'd13, 4'd0});
        drive(1'b0, 2'b10, 2'b00, {4'd14, 4'd0});
        idle(16, 2'b00);
        drive(1'b0, 2'b10, 2'b00, {4'd3, 4'd0});
        drive(1'b0, 2'b10, 2'b00, {4'd5, 4'd0});
        idle(5, 2'b00);

        // dly=0 behaves as dly=1.
        drive(1'b0, 2'b11, 2'b01, {4'd0, 4'd0});
        drive(1'b0, 2'b11, 2'b01, {4'd0, 4'd0});
        idle(3, 2'b01);

        // Random traffic with varying density, mode churn and rare resets.
        rm = '0;
        density = 50;
        for (int i = 0; i < 4000; i++) begin
            if ((i % 200) == 0) density = $urandom_range(5, 95);
            for (int c = 0; c < NCH; c++) begin
                rt[c] = ($urandom_range(0, 99) < density);
                if ($urandom_range(0, 19) == 0) rm[c] = ~rm[c];
            end
            for (int c = 0; c < NCH; c++) begin
                rd[c*DW +: DW] = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3))
                                                             : DW'($urandom_range(0, 15));
            end
            drive(($urandom_range(0, 599) == 0), rt, rm, rd);
        end
        idle(20, rm);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
